seg_ramp_ctrl: RTL and testbench

// Digital controller for a parametrised bank of parallel, individually gated

---
 rtl/seg_ramp_ctrl.sv | 107 ++++++++++
 tb/tb_seg_ramp_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_ramp_ctrl.sv
// Segment-bank gate ramp controller: accepts a target segment count and steps a
// thermometer-coded enable bus toward it, one segment every STEP_DIV cycles.
module seg_ramp_ctrl #(
    parameter int NSEG     = 8,
    parameter int CW       = $clog2(NSEG + 1),
    parameter int STEP_DIV = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CW-1:0]   tgt_val,
    input  logic            tgt_vld,
    output logic            tgt_rdy,
    input  logic            hold,
    output logic [NSEG-1:0] seg_en,
    output logic [CW-1:0]   cur_cnt,
    output logic            busy,
    output logic            done
);

    localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
    localparam logic [CW-1:0] NSEG_CW  = CW'(NSEG);

    typedef enum logic {
        IDLE,
        RAMP
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   tgt_q, tgt_d;
    logic            done_q, done_d;
    logic [NSEG-1:0] seg_en_q, seg_en_d;
    logic [CW-1:0]   tgt_sat;

    assign tgt_sat = (tgt_val > NSEG_CW) ? NSEG_CW : tgt_val;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (tgt_vld) begin
                    tgt_d = tgt_sat;
                    if (tgt_sat == cnt_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RAMP;
                        div_d   = '0;
                    end
                end
            end
            RAMP: begin
                if (!hold) begin
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        cnt_d = (tgt_q > cnt_q) ? cnt_q + 1'b1 : cnt_q - 1'b1;
                        if (cnt_d == tgt_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Enables are decoded from the next count so they change on the same edge.
    always_comb begin
        seg_en_d = '0;
        for (int unsigned i = 0; i < NSEG; i++) begin
            seg_en_d[i] = (CW'(i) < cnt_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            cnt_q    <= '0;
            tgt_q    <= '0;
            done_q   <= 1'b0;
            seg_en_q <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            tgt_q    <= tgt_d;
            done_q   <= done_d;
            seg_en_q <= seg_en_d;
        end
    end

    assign tgt_rdy = (state_q == IDLE);
    assign busy    = (state_q == RAMP);
    assign done    = done_q;
    assign cur_cnt = cnt_q;
    assign seg_en  = seg_en_q;

endmodule

// File: tb/tb_seg_ramp_ctrl.sv
module tb_seg_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] tgt_val = '0;
  logic       tgt_vld = 1'b0;
  logic       hold = 1'b0;
  logic       tgt_rdy, busy, done;
  logic [7:0] seg_en;
  logic [3:0] cur_cnt;

  logic [1:0] tgt_val1 = '0;
  logic       tgt_vld1 = 1'b0;
  logic       tgt_rdy1, busy1, done1;
  logic [2:0] seg_en1;
  logic [1:0] cur_cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg_ramp_ctrl #(.NSEG(8), .STEP_DIV(4)) dut (
    .clk(clk), .rst(rst), .tgt_val(tgt_val), .tgt_vld(tgt_vld),
    .tgt_rdy(tgt_rdy), .hold(hold), .seg_en(seg_en), .cur_cnt(cur_cnt),
    .busy(busy), .done(done)
  );

  seg_ramp_ctrl #(.NSEG(3), .STEP_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .tgt_val(tgt_val1), .tgt_vld(tgt_vld1),
    .tgt_rdy(tgt_rdy1), .hold(1'b0), .seg_en(seg_en1), .cur_cnt(cur_cnt1),
    .busy(busy1), .done(done1)
  );

  function automatic logic [7:0] therm(input int n);
    therm = 8'((1 << n) - 1);
  endfunction

  task automatic do_accept(input logic [3:0] v);
    @(negedge clk);
    tgt_val = v;
    tgt_vld = 1'b1;
    @(negedge clk);
    tgt_vld = 1'b0;
  endtask

  task automatic do_accept1(input logic [1:0] v);
    @(negedge clk);
    tgt_val1 = v;
    tgt_vld1 = 1'b1;
    @(negedge clk);
    tgt_vld1 = 1'b0;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_tests++;
    if ({seg_en, cur_cnt, busy, done, tgt_rdy} !== {8'h00, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_async: en=%h cnt=%0d busy=%b done=%b rdy=%b, want 00/0/0/0/1",
               seg_en, cur_cnt, busy, done, tgt_rdy);
    end
    tgt_val = 4'd5;
    tgt_vld = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({seg_en, cur_cnt, busy, done, tgt_rdy} !== {8'h00, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_clocked: en=%h cnt=%0d busy=%b done=%b rdy=%b, want 00/0/0/0/1",
               seg_en, cur_cnt, busy, done, tgt_rdy);
    end
    tgt_vld = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_ramp_up;
    logic [3:0] e;
    do_accept(4'd5);
    n_tests++;
    if ({busy, tgt_rdy, cur_cnt, done} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL up_accept: busy=%b rdy=%b cnt=%0d done=%b, want 1/0/0/0",
               busy, tgt_rdy, cur_cnt, done);
    end
    for (int unsigned k = 1; k <= 21; k++) begin
      @(negedge clk);
      e = (k >= 20) ? 4'd5 : 4'(k / 4);
      n_tests++;
      if ({cur_cnt, seg_en, busy, done, tgt_rdy} !== {e, therm(int'(e)), k < 20, k == 20, k >= 20}) begin
        n_fail++;
        $display("FAIL up_k%0d: cnt=%0d en=%h busy=%b done=%b rdy=%b, want cnt=%0d en=%h busy=%b done=%b",
                 k, cur_cnt, seg_en, busy, done, tgt_rdy, e, therm(int'(e)), k < 20, k == 20);
      end
    end
  endtask

  task automatic test_ramp_down;
    logic [3:0] e;
    do_accept(4'd2);
    for (int unsigned k = 1; k <= 13; k++) begin
      @(negedge clk);
      e = (k >= 12) ? 4'd2 : 4'(5 - k / 4);
      n_tests++;
      if ({cur_cnt, seg_en, busy, done} !== {e, therm(int'(e)), k < 12, k == 12}) begin
        n_fail++;
        $display("FAIL down_k%0d: cnt=%0d en=%h busy=%b done=%b, want cnt=%0d en=%h busy=%b done=%b",
                 k, cur_cnt, seg_en, busy, done, e, therm(int'(e)), k < 12, k == 12);
      end
    end
  endtask

  task automatic test_saturate;
    logic [3:0] e;
    apply_reset();
    do_accept(4'd12);
    for (int unsigned k = 1; k <= 33; k++) begin
      @(negedge clk);
      e = (k >= 32) ? 4'd8 : 4'(k / 4);
      n_tests++;
      if ({cur_cnt, seg_en, busy, done} !== {e, therm(int'(e)), k < 32, k == 32}) begin
        n_fail++;
        $display("FAIL sat_k%0d: cnt=%0d en=%h busy=%b done=%b, want cnt=%0d en=%h busy=%b done=%b",
                 k, cur_cnt, seg_en, busy, done, e, therm(int'(e)), k < 32, k == 32);
      end
    end
    n_tests++;
    if (seg_en !== 8'hFF || cur_cnt !== 4'd8) begin
      n_fail++;
      $display("FAIL sat_final: en=%h cnt=%0d, want ff/8", seg_en, cur_cnt);
    end
  endtask

  task automatic test_hold;
    logic [3:0] e;
    int eff;
    apply_reset();
    do_accept(4'd4);
    for (int unsigned k = 1; k <= 20; k++) begin
      hold = (k >= 6 && k <= 8);
      @(negedge clk);
      eff = (k <= 5) ? int'(k) : ((k <= 8) ? 5 : int'(k) - 3);
      e = (eff >= 16) ? 4'd4 : 4'(eff / 4);
      n_tests++;
      if ({cur_cnt, seg_en, busy, done} !== {e, therm(int'(e)), k < 19, k == 19}) begin
        n_fail++;
        $display("FAIL hold_k%0d: cnt=%0d en=%h busy=%b done=%b, want cnt=%0d en=%h busy=%b done=%b",
                 k, cur_cnt, seg_en, busy, done, e, therm(int'(e)), k < 19, k == 19);
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_equal_and_drop;
    logic [3:0] e;
    do_accept(4'd3);
    repeat (4) @(negedge clk);
    n_tests++;
    if ({cur_cnt, done, busy} !== {4'd3, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL eq_setup: cnt=%0d done=%b busy=%b, want 3/1/0", cur_cnt, done, busy);
    end
    do_accept(4'd3);
    n_tests++;
    if ({cur_cnt, seg_en, busy, done, tgt_rdy} !== {4'd3, 8'h07, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL eq_done: cnt=%0d en=%h busy=%b done=%b rdy=%b, want 3/07/0/1/1",
               cur_cnt, seg_en, busy, done, tgt_rdy);
    end
    @(negedge clk);
    n_tests++;
    if ({cur_cnt, seg_en, busy, done} !== {4'd3, 8'h07, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL eq_after: cnt=%0d en=%h busy=%b done=%b, want 3/07/0/0",
               cur_cnt, seg_en, busy, done);
    end
    do_accept(4'd6);
    for (int unsigned k = 1; k <= 13; k++) begin
      if (k == 5) begin
        tgt_val = 4'd0;
        tgt_vld = 1'b1;
      end
      if (k == 7) tgt_vld = 1'b0;
      @(negedge clk);
      e = (k >= 12) ? 4'd6 : 4'(3 + k / 4);
      n_tests++;
      if ({cur_cnt, seg_en, busy, done} !== {e, therm(int'(e)), k < 12, k == 12}) begin
        n_fail++;
        $display("FAIL drop_k%0d: cnt=%0d en=%h busy=%b done=%b, want cnt=%0d en=%h busy=%b done=%b",
                 k, cur_cnt, seg_en, busy, done, e, therm(int'(e)), k < 12, k == 12);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] e;
    apply_reset();
    do_accept(4'd5);
    repeat (12) @(negedge clk);
    n_tests++;
    if (cur_cnt !== 4'd3 || seg_en !== 8'h07) begin
      n_fail++;
      $display("FAIL rmid_pre: cnt=%0d en=%h, want 3/07", cur_cnt, seg_en);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({seg_en, cur_cnt, busy, done, tgt_rdy} !== {8'h00, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rmid_async: en=%h cnt=%0d busy=%b done=%b rdy=%b, want 00/0/0/0/1",
               seg_en, cur_cnt, busy, done, tgt_rdy);
    end
    @(negedge clk);
    rst = 1'b0;
    do_accept(4'd2);
    for (int unsigned k = 1; k <= 9; k++) begin
      @(negedge clk);
      e = (k >= 8) ? 4'd2 : 4'(k / 4);
      n_tests++;
      if ({cur_cnt, seg_en, busy, done} !== {e, therm(int'(e)), k < 8, k == 8}) begin
        n_fail++;
        $display("FAIL rmid_k%0d: cnt=%0d en=%h busy=%b done=%b, want cnt=%0d en=%h busy=%b done=%b",
                 k, cur_cnt, seg_en, busy, done, e, therm(int'(e)), k < 8, k == 8);
      end
    end
  endtask

  task automatic test_step1;
    logic [1:0] e;
    logic [7:0] t;
    do_accept1(2'd3);
    for (int unsigned k = 1; k <= 4; k++) begin
      @(negedge clk);
      e = (k >= 3) ? 2'd3 : 2'(k);
      t = therm(int'(e));
      n_tests++;
      if ({cur_cnt1, seg_en1, busy1, done1, tgt_rdy1} !== {e, t[2:0], k < 3, k == 3, k >= 3}) begin
        n_fail++;
        $display("FAIL s1up_k%0d: cnt=%0d en=%h busy=%b done=%b rdy=%b, want cnt=%0d en=%h done=%b",
                 k, cur_cnt1, seg_en1, busy1, done1, tgt_rdy1, e, t[2:0], k == 3);
      end
    end
    do_accept1(2'd0);
    for (int unsigned k = 1; k <= 4; k++) begin
      @(negedge clk);
      e = (k >= 3) ? 2'd0 : 2'(3 - k);
      t = therm(int'(e));
      n_tests++;
      if ({cur_cnt1, seg_en1, busy1, done1} !== {e, t[2:0], k < 3, k == 3}) begin
        n_fail++;
        $display("FAIL s1dn_k%0d: cnt=%0d en=%h busy=%b done=%b, want cnt=%0d en=%h done=%b",
                 k, cur_cnt1, seg_en1, busy1, done1, e, t[2:0], k == 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_saturate();
    test_hold();
    test_equal_and_drop();
    test_reset_mid();
    test_step1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
